fp_addsub_dispatch: RTL and testbench

- Front-end stage directly upstream of the single-precision add/subtract core.
- Accepts custom-instruction requests carrying an opcode and two IEEE-754 operands.
- Resolves special operands (NaN/Inf/denormal) and trivial ops (neg/abs) locally. Issues only normal add/sub work to the core and waits for its result.
- Returns a single-cycle done pulse with a held result to the processor side.

---
 rtl/fp_pkg.sv | 22 ++
 rtl/fp_classify.sv | 29 ++
 rtl/fp_addsub_dispatch.sv | 157 +++++++++++++++
 tb/tb_fp_addsub_dispatch.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field layout, opcodes and dispatch FSM encoding.
package fp_pkg;

    localparam int unsigned SIGN_BIT = 31;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MANT_W   = 23;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_NEG = 2'd2;
    localparam logic [1:0] OP_ABS = 2'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_EVAL  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier; works on the magnitude bits only (sign is irrelevant).
module fp_classify
    import fp_pkg::*;
(
    input  logic [SIGN_BIT-1:0] i_mag,
    output logic                o_is_zero,
    output logic                o_is_denorm,
    output logic                o_is_inf,
    output logic                o_is_nan
);

    logic [EXP_W-1:0]  w_exp;
    logic [MANT_W-1:0] w_mant;
    logic              w_exp_zero;
    logic              w_exp_max;
    logic              w_mant_zero;

    assign w_exp       = i_mag[SIGN_BIT-1 -: EXP_W];
    assign w_mant      = i_mag[MANT_W-1:0];
    assign w_exp_zero  = (w_exp == '0);
    assign w_exp_max   = (w_exp == EXP_MAX);
    assign w_mant_zero = (w_mant == '0);

    assign o_is_zero   = w_exp_zero &  w_mant_zero;
    assign o_is_denorm = w_exp_zero & ~w_mant_zero;
    assign o_is_inf    = w_exp_max  &  w_mant_zero;
    assign o_is_nan    = w_exp_max  & ~w_mant_zero;

endmodule

// File: rtl/fp_addsub_dispatch.sv
// Front-end for the FP add/sub core: resolves special operands and neg/abs locally,
// forwards normal work to the core and returns a one-cycle done with a held result.
module fp_addsub_dispatch
    import fp_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned WAIT_MIN = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  n,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        err_timeout,
    output logic        core_enable,
    output logic [31:0] core_dataa,
    output logic [31:0] core_datab,
    input  logic [31:0] core_result,
    input  logic        core_done
);

    localparam int unsigned    CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_ONE  = 1;
    localparam logic [CNT_W-1:0] C_WMIN = CNT_W'(WAIT_MIN);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]       r_state;
    logic [1:0]       r_n;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_result;
    logic             r_err;
    logic [31:0]      r_core_a;
    logic [31:0]      r_core_b;
    logic [CNT_W-1:0] r_cnt;

    logic w_a_zero, w_a_denorm, w_a_inf, w_a_nan;
    logic w_b_zero, w_b_denorm, w_b_inf, w_b_nan;

    fp_classify u_class_a (
        .i_mag       (r_a[SIGN_BIT-1:0]),
        .o_is_zero   (w_a_zero),
        .o_is_denorm (w_a_denorm),
        .o_is_inf    (w_a_inf),
        .o_is_nan    (w_a_nan)
    );

    fp_classify u_class_b (
        .i_mag       (r_b[SIGN_BIT-1:0]),
        .o_is_zero   (w_b_zero),
        .o_is_denorm (w_b_denorm),
        .o_is_inf    (w_b_inf),
        .o_is_nan    (w_b_nan)
    );

    logic [31:0] w_a_flush;
    logic [31:0] w_b_flush;
    logic [31:0] w_b_adj;
    logic        w_bypass;
    logic [31:0] w_byp_res;

    // Zero and denormal both collapse to a signed zero; subtraction is folded into B's sign.
    assign w_a_flush = (w_a_zero | w_a_denorm) ? {r_a[SIGN_BIT], 31'b0} : r_a;
    assign w_b_flush = (w_b_zero | w_b_denorm) ? {r_b[SIGN_BIT], 31'b0} : r_b;
    assign w_b_adj   = (r_n == OP_SUB) ? {~w_b_flush[SIGN_BIT], w_b_flush[SIGN_BIT-1:0]}
                                       : w_b_flush;

    always_comb begin
        w_bypass  = 1'b1;
        w_byp_res = QNAN;
        case (r_n)
            OP_NEG: w_byp_res = r_a ^ 32'h8000_0000;
            OP_ABS: w_byp_res = r_a & 32'h7FFF_FFFF;
            default: begin
                if (w_a_nan || w_b_nan) begin
                    w_byp_res = QNAN;
                end else if (w_a_inf && w_b_inf) begin
                    w_byp_res = (r_a[SIGN_BIT] == w_b_adj[SIGN_BIT]) ? r_a : QNAN;
                end else if (w_a_inf) begin
                    w_byp_res = r_a;
                end else if (w_b_inf) begin
                    w_byp_res = w_b_adj;
                end else begin
                    w_bypass = 1'b0;
                end
            end
        endcase
    end

    // r_cnt counts enabled edges, so the first WAIT cycle already sees 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_n      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_core_a <= '0;
            r_core_b <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_n     <= n;
                        r_a     <= dataa;
                        r_b     <= datab;
                        r_state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    r_err <= 1'b0;
                    if (w_bypass) begin
                        r_result <= w_byp_res;
                        r_state  <= ST_RESP;
                    end else begin
                        r_core_a <= w_a_flush;
                        r_core_b <= w_b_adj;
                        r_cnt    <= '0;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= r_cnt + C_ONE;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + C_ONE;
                    if (core_done && (r_cnt >= C_WMIN)) begin
                        r_result <= core_result;
                        r_state  <= ST_RESP;
                    end else if (r_cnt == C_LAST) begin
                        r_result <= QNAN;
                        r_err    <= 1'b1;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign result      = r_result;
    assign done        = (r_state == ST_RESP);
    assign busy        = (r_state != ST_IDLE);
    assign err_timeout = done & r_err;
    assign core_enable = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign core_dataa  = r_core_a;
    assign core_datab  = r_core_b;

endmodule

// File: tb/tb_fp_addsub_dispatch.sv
// Scoreboard bench for fp_addsub_dispatch with a configurable add/sub core model.
module tb_fp_addsub_dispatch;

    localparam int unsigned TIMEOUT  = 16;
    localparam int unsigned WAIT_MIN = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  n = 2'd0;
    logic [31:0] dataa = '0;
    logic [31:0] datab = '0;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        err_timeout;
    logic        core_enable;
    logic [31:0] core_dataa;
    logic [31:0] core_datab;
    logic [31:0] core_result = '0;
    logic        core_done = 1'b0;

    fp_addsub_dispatch #(.TIMEOUT(TIMEOUT), .WAIT_MIN(WAIT_MIN)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .n           (n),
        .dataa       (dataa),
        .datab       (datab),
        .result      (result),
        .done        (done),
        .busy        (busy),
        .err_timeout (err_timeout),
        .core_enable (core_enable),
        .core_dataa  (core_dataa),
        .core_datab  (core_datab),
        .core_result (core_result),
        .core_done   (core_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          lat;
        bit          core;
        logic [31:0] ca;
        logic [31:0] cb;
        int          s;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   prev_done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Core model: on the m_lat-th enabled edge it raises done and drives m_res.
    int          m_lat = 1;
    bit          m_clear = 1'b0;
    logic [31:0] m_res = '0;
    int          en_cnt = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n || !core_enable) begin
            en_cnt = 0;
        end else begin
            en_cnt++;
            if (en_cnt == 1 && m_clear) core_done <= 1'b0;
            if (en_cnt == m_lat) begin
                core_done   <= 1'b1;
                core_result <= m_res;
            end
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (prev_done) chk("busy_after_done", {31'b0, busy}, 32'd0);
            if (core_enable) begin
                if (q.size() == 0 || !q[0].core) begin
                    checks++;
                    errors++;
                    $display("FAIL core_enable_unexpected: got 1 expected 0");
                end else begin
                    chk("core_dataa", core_dataa, q[0].ca);
                    chk("core_datab", core_datab, q[0].cb);
                end
            end
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected none, result %h", result);
                end else begin
                    e = q.pop_front();
                    chk("result", result, e.res);
                    chk("err_timeout", {31'b0, err_timeout}, {31'b0, e.err});
                    chk("latency", cyc - e.s, e.lat);
                end
            end
        end
        prev_done = done;
    end

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout: got no done expected done within 60 cycles");
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic err, input int lat,
                         input bit core, input logic [31:0] ca, input logic [31:0] cb);
        exp_t e;
        @(negedge clk);
        n = op; dataa = a; datab = b; start = 1'b1;
        e.res = res; e.err = err; e.lat = lat; e.core = core; e.ca = ca; e.cb = cb;
        e.s = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic err, input int lat,
                          input bit core, input logic [31:0] ca, input logic [31:0] cb);
        issue(op, a, b, res, err, lat, core, ca, cb);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        chk("rst_result", result, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_err", {31'b0, err_timeout}, 32'd0);
        chk("rst_core_en", {31'b0, core_enable}, 32'd0);
        chk("rst_core_a", core_dataa, 32'd0);
        chk("rst_core_b", core_datab, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        m_lat = 2; m_clear = 1'b1; m_res = 32'h4040_0000;
        run_op(2'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 4, 1'b1,
               32'h3F80_0000, 32'h4000_0000);
        m_res = 32'h4000_0000;
        run_op(2'd1, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 4, 1'b1,
               32'h4040_0000, 32'hBF80_0000);

        run_op(2'd0, 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1, 1'b0, '0, '0);
        run_op(2'd0, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b0, 1, 1'b0, '0, '0);
        run_op(2'd0, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b0, 1, 1'b0, '0, '0);
        run_op(2'd1, 32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000, 1'b0, 1, 1'b0, '0, '0);
        run_op(2'd0, 32'hFF80_0000, 32'hFF80_0000, 32'hFF80_0000, 1'b0, 1, 1'b0, '0, '0);
        run_op(2'd2, 32'h3F80_0000, 32'h1234_5678, 32'hBF80_0000, 1'b0, 1, 1'b0, '0, '0);
        run_op(2'd3, 32'hC0A0_0000, 32'h7FC0_0001, 32'h40A0_0000, 1'b0, 1, 1'b0, '0, '0);
        run_op(2'd2, 32'h7FC0_0001, 32'h0000_0000, 32'hFFC0_0001, 1'b0, 1, 1'b0, '0, '0);

        m_lat = 1; m_clear = 1'b1; m_res = 32'h3F80_0000;
        run_op(2'd0, 32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 3, 1'b1,
               32'h0000_0000, 32'h3F80_0000);
        run_op(2'd1, 32'h3F80_0000, 32'h8000_0005, 32'h3F80_0000, 1'b0, 3, 1'b1,
               32'h3F80_0000, 32'h0000_0000);

        m_lat = 1000; m_clear = 1'b1;
        run_op(2'd0, 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, 17, 1'b1,
               32'h3F80_0000, 32'h3F80_0000);

        // Sticky done: second op starts with core_done already high.
        m_lat = 1; m_clear = 1'b0; m_res = 32'h4000_0000;
        run_op(2'd0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 3, 1'b1,
               32'h3F80_0000, 32'h3F80_0000);
        m_res = 32'h4080_0000;
        run_op(2'd0, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0, 3, 1'b1,
               32'h4000_0000, 32'h4000_0000);

        m_lat = 3; m_clear = 1'b1; m_res = 32'h40C0_0000;
        issue(2'd0, 32'h4000_0000, 32'h4080_0000, 32'h40C0_0000, 1'b0, 5, 1'b1,
              32'h4000_0000, 32'h4080_0000);
        n = 2'd2; dataa = 32'hDEAD_BEEF; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (6) @(negedge clk);

        m_lat = 1000; m_clear = 1'b1;
        issue(2'd0, 32'h3F80_0000, 32'h4000_0000, 32'h0, 1'b0, 0, 1'b1,
              32'h3F80_0000, 32'h4000_0000);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_core_en", {31'b0, core_enable}, 32'd0);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_done", {31'b0, done}, 32'd0);
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_core_b", core_datab, 32'd0);
        repeat (6) @(negedge clk);

        run_op(2'd3, 32'h8000_0000, 32'h0, 32'h0000_0000, 1'b0, 1, 1'b0, '0, '0);
        repeat (4) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
